// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: one position per clock under a start/done handshake.
// Define SEQ_SHIFT_ROTATE_EN to build ROR for mode 11; otherwise mode 11 behaves as LSR.
module seq_shift_unit #(
  parameter int N     = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     d,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     q,
  output logic             carry
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
`ifdef SEQ_SHIFT_ROTATE_EN
  localparam logic [1:0] M_ROR = 2'b11;
`endif

  state_t           state;
  logic [AMT_W-1:0] count;
  logic [1:0]       mode_r;
  logic [N-1:0]     q_nxt;
  logic             carry_nxt;

  // Single-step shifter; anything not matched (incl. 11 without rotate) is LSR.
  always_comb begin
    q_nxt     = {1'b0, q[N-1:1]};
    carry_nxt = q[0];
    case (mode_r)
      M_LSL: begin
        q_nxt     = {q[N-2:0], 1'b0};
        carry_nxt = q[N-1];
      end
      M_LSR: q_nxt = {1'b0, q[N-1:1]};
      M_ASR: q_nxt = {q[N-1], q[N-1:1]};
`ifdef SEQ_SHIFT_ROTATE_EN
      M_ROR: q_nxt = {q[0], q[N-1:1]};
`endif
      default: q_nxt = {1'b0, q[N-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q      <= '0;
      carry  <= 1'b0;
      count  <= '0;
      mode_r <= M_LSL;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q      <= d;
            carry  <= 1'b0;
            count  <= amount;
            mode_r <= mode;
            if (amount == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          q     <= q_nxt;
          carry <= carry_nxt;
          count <= count - 1'b1;
          // count never reaches 0 here: a zero amount bypasses SHIFT entirely
          if (count == AMT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: driver pushes reference results, monitor checks on done.
module tb_seq_shift_unit;

  localparam int N     = 8;
  localparam int AMT_W = 3;
`ifdef SEQ_SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N-1:0]     d = '0;
  logic [1:0]       mode = '0;
  logic [AMT_W-1:0] amount = '0;
  logic             busy, done, carry;
  logic [N-1:0]     q;

  seq_shift_unit #(.N(N), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d(d), .mode(mode),
    .amount(amount), .busy(busy), .done(done), .q(q), .carry(carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] q;
    logic         c;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: whole-operand arithmetic over a double-width window.
  function automatic logic [N:0] ref_op(input logic [N-1:0] dd, input logic [1:0] mm,
                                        input int a);
    logic [2*N-1:0]        w;
    logic signed [2*N-1:0] s;
    logic [N-1:0]          r;
    logic                  c;
    int                    k;
    c = 1'b0;
    if (mm == 2'b00) begin
      w = {{N{1'b0}}, dd} << a;
      r = w[N-1:0];
      if (a > 0) c = (a <= N) ? w[N] : 1'b0;
    end else if (mm == 2'b10) begin
      s = $signed({dd, {N{1'b0}}}) >>> a;
      r = s[2*N-1:N];
      if (a > 0) c = s[N-1];
    end else if (mm == 2'b11 && ROT) begin
      k = a % N;
      r = (dd >> k) | (dd << (N - k));
      if (a > 0) c = r[N-1];
    end else begin
      w = {dd, {N{1'b0}}} >> a;
      r = w[2*N-1:N];
      if (a > 0) c = w[N-1];
    end
    return {c, r};
  endfunction

  // Called at a negedge; returns at the negedge inside the DONE cycle.
  task automatic issue(input logic [N-1:0] dd, input logic [1:0] mm, input int a);
    logic [N:0] r;
    exp_t e;
    r = ref_op(dd, mm, a);
    e.q = r[N-1:0]; e.c = r[N]; e.cyc = cyc + 1 + a;
    exp_q.push_back(e);
    start = 1'b1; d = dd; mode = mm; amount = AMT_W'(a);
    @(negedge clk);
    start = 1'b0;
    repeat (a) @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        chk("busy_in_done", {31'b0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("q", {24'b0, q}, {24'b0, e.q});
          chk("carry", {31'b0, carry}, {31'b0, e.c});
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int a;
    // Reset values
    #2;
    chk("rst_q", {24'b0, q}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_carry", {31'b0, carry}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-shift: the partial result is discarded, no done follows
    start = 1'b1; d = 8'h81; mode = 2'b00; amount = 3'd5;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", {24'b0, q}, 32'd0);
    chk("mid_rst_carry", {31'b0, carry}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_done", {31'b0, done}, 32'd0);
    chk("post_rst_q", {24'b0, q}, 32'd0);

    // Directed cases
    issue(8'hB5, 2'b00, 3); @(negedge clk);
    issue(8'hB5, 2'b01, 3); @(negedge clk);
    issue(8'h90, 2'b10, 7); @(negedge clk);
    issue(8'h90, 2'b01, 7); @(negedge clk);
    issue(8'h81, 2'b11, 1); @(negedge clk);

    // Zero amount then back-to-back LSL
    start = 1'b1; d = 8'h3C; mode = 2'b00; amount = 3'd0;
    begin
      exp_t e;
      e.q = 8'h3C; e.c = 1'b0; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    chk("zero_amt_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    issue(8'h01, 2'b00, 2);
    @(negedge clk);

    // Start while busy is ignored
    begin
      exp_t e;
      e.q = 8'h0F; e.c = 1'b0; e.cyc = cyc + 1 + 4;
      exp_q.push_back(e);
    end
    start = 1'b1; d = 8'hF0; mode = 2'b01; amount = 3'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; d = 8'h00; mode = 2'b00; amount = 3'd1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized operations, sometimes back-to-back
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, 7));
      issue(N'($urandom), 2'($urandom_range(0, 3)), a);
      if ($urandom_range(0, 2) != 0) @(negedge clk);
    end
    @(negedge clk);

    // Drain with a bounded wait
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
